// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module   : if_fetch_stage
// Brief    : MIPS instruction-fetch stage: PC, ROM addressing, IF/ID register,
//            stall/flush, redirect, interrupt and exception vectoring.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [30:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        irq_req,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        id_irq
);

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc_plus4;
  logic        r_id_valid;
  logic        r_id_irq;

  logic [31:0] w_seq_pc;
  logic [31:0] w_redirect_pc;
  logic        w_irq_taken;

  // Incrementing never crosses the supervisor bit; user code cannot jump into kernel space.
  assign w_seq_pc      = {r_pc[31], r_pc[30:0] + 31'd4};
  assign w_redirect_pc = {r_pc[31] & redirect_target[31], redirect_target[30:2], 2'b00};
  assign w_irq_taken   = irq_req & ~r_pc[31] & ~stall;

  assign rom_addr    = r_pc[30:0];
  assign pc          = r_pc;
  assign id_instr    = r_id_instr;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign id_valid    = r_id_valid;
  assign id_irq      = r_id_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_id_instr    <= NOP;
      r_id_pc_plus4 <= 32'h0;
      r_id_valid    <= 1'b0;
      r_id_irq      <= 1'b0;
    end else if (exc_req) begin
      r_pc          <= EXC_VEC;
      r_id_instr    <= NOP;
      r_id_pc_plus4 <= 32'h0;
      r_id_valid    <= 1'b0;
      r_id_irq      <= 1'b0;
    end else if (w_irq_taken) begin
      // The unfetched instruction's address becomes the EPC.
      r_pc          <= IRQ_VEC;
      r_id_instr    <= NOP;
      r_id_pc_plus4 <= r_pc;
      r_id_valid    <= 1'b0;
      r_id_irq      <= 1'b1;
    end else if (redirect_valid) begin
      r_pc          <= w_redirect_pc;
      r_id_instr    <= NOP;
      r_id_pc_plus4 <= 32'h0;
      r_id_valid    <= 1'b0;
      r_id_irq      <= 1'b0;
    end else if (stall) begin
      r_pc          <= r_pc;
    end else if (flush) begin
      r_pc          <= w_seq_pc;
      r_id_instr    <= NOP;
      r_id_pc_plus4 <= 32'h0;
      r_id_valid    <= 1'b0;
      r_id_irq      <= 1'b0;
    end else begin
      r_pc          <= w_seq_pc;
      r_id_instr    <= rom_data;
      r_id_pc_plus4 <= w_seq_pc;
      r_id_valid    <= 1'b1;
      r_id_irq      <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Self-checking bench for if_fetch_stage against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

  localparam logic [31:0] C_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] C_IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] C_EXC_VEC  = 32'h8000_0008;
  localparam logic [31:0] C_NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [30:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        irq_req = 1'b0;
  logic        exc_req = 1'b0;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        id_irq;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_irq;

  if_fetch_stage #(
    .RESET_PC(C_RESET_PC), .IRQ_VEC(C_IRQ_VEC), .EXC_VEC(C_EXC_VEC), .NOP(C_NOP)
  ) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .irq_req(irq_req), .exc_req(exc_req),
    .pc(pc), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid), .id_irq(id_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [30:0] a);
    if (a == 31'd0) return 32'h3c11_4000;
    return ({1'b0, a} * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = C_RESET_PC; m_instr = C_NOP; m_pp4 = 32'h0; m_valid = 1'b0; m_irq = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},       pc,                 m_pc);
    chk({tag, ".rom_addr"}, {1'b0, rom_addr},   {1'b0, m_pc[30:0]});
    chk({tag, ".instr"},    id_instr,           m_instr);
    chk({tag, ".pp4"},      id_pc_plus4,        m_pp4);
    chk({tag, ".valid"},    {31'b0, id_valid},  {31'b0, m_valid});
    chk({tag, ".irq"},      {31'b0, id_irq},    {31'b0, m_irq});
  endtask

  // Apply inputs, advance the model by the priority rules, clock once and compare.
  task automatic step(input string tag, input logic e, input logic i, input logic rv,
                      input logic [31:0] rt, input logic s, input logic f);
    logic [31:0] seq;
    exc_req = e; irq_req = i; redirect_valid = rv; redirect_target = rt;
    stall = s; flush = f;
    seq = {m_pc[31], m_pc[30:0] + 31'd4};
    if (e) begin
      m_pc = C_EXC_VEC; m_instr = C_NOP; m_pp4 = 0; m_valid = 0; m_irq = 0;
    end else if (i && !m_pc[31] && !s) begin
      m_pp4 = m_pc; m_pc = C_IRQ_VEC; m_instr = C_NOP; m_valid = 0; m_irq = 1;
    end else if (rv) begin
      m_pc = {m_pc[31] & rt[31], rt[30:2], 2'b00};
      m_instr = C_NOP; m_pp4 = 0; m_valid = 0; m_irq = 0;
    end else if (s) begin
      // hold everything
    end else if (f) begin
      m_pc = seq; m_instr = C_NOP; m_pp4 = 0; m_valid = 0; m_irq = 0;
    end else begin
      m_instr = rom_fn(m_pc[30:0]); m_pp4 = seq; m_pc = seq; m_valid = 1; m_irq = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic go(input string tag);
    step(tag, 0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic jump(input string tag, input logic [31:0] t);
    step(tag, 0, 0, 1, t, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.rom_addr0", {1'b0, rom_addr}, 32'h0);
    reset = 1'b1;

    // Fetch from reset vector
    go("fetch0");
    chk("fetch0.instr_k", id_instr, 32'h3c11_4000);
    chk("fetch0.pp4_k", id_pc_plus4, 32'h8000_0004);
    go("fetch1");

    // Stall holds PC and IF/ID
    step("stall0", 0, 0, 0, 32'h0, 1, 0);
    step("stall1", 0, 0, 0, 32'h0, 1, 0);
    chk("stall.pc_k", pc, 32'h8000_0008);
    go("resume0");
    go("resume1");

    // Redirect overrides stall; user code cannot enter kernel space
    step("redir_stall", 0, 0, 1, 32'h8000_0054, 1, 0);
    chk("redir_stall.pc_k", pc, 32'h8000_0054);
    jump("to_user", 32'h0000_0020);
    jump("user_to_kern", 32'h8000_0000);
    chk("user_to_kern.pc_k", pc, 32'h0000_0000);
    jump("user_jump", 32'h0000_0022);

    // Interrupt from user, ignored in kernel
    step("irq_user", 0, 1, 0, 32'h0, 0, 0);
    chk("irq_user.epc_k", id_pc_plus4, 32'h0000_0020);
    jump("to_kern30", 32'h8000_0030);
    step("irq_kern", 0, 1, 0, 32'h0, 0, 0);
    chk("irq_kern.pc_k", pc, 32'h8000_0034);

    // Deferred interrupt while stalled in user mode
    jump("to_user40", 32'h0000_0040);
    step("irq_stall", 0, 1, 0, 32'h0, 1, 0);
    step("irq_after", 0, 1, 0, 32'h0, 0, 0);

    // Everything at once: exception wins
    step("all_req", 1, 1, 1, 32'h0000_0100, 1, 1);
    chk("all_req.pc_k", pc, 32'h8000_0008);

    // Flush, and stall+flush
    go("pre_flush");
    step("flush", 0, 0, 0, 32'h0, 0, 1);
    step("stall_flush", 0, 0, 0, 32'h0, 1, 1);

    // Wrap in user space and in kernel space
    jump("to_wrap_u", 32'h7FFF_FFFC);
    go("wrap_u");
    chk("wrap_u.pc_k", pc, 32'h0000_0000);
    jump("to_wrap_k", 32'h0000_0000);
    jump("kern_again", 32'h8000_0000);
    chk("kern_again.pc_k", pc, 32'h0000_0000);

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      logic [31:0] t;
      t = $urandom;
      step("rand",
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 1) == 0) ? t : {t[31], 19'h0, t[11:0]},
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset mid-cycle
    go("pre_rst");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    reset = 1'b1;
    go("post_rst0");
    go("post_rst1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
